instruction_encoder: RTL

Inverse of the instruction decode stage: takes decoded fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) and packs them into a 32-bit RV32I word. Used by the program loader and the self-checking benches to generate instruction streams into instruction memory.

---
 rtl/instruction_encoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// Packs decoded RV32I fields into a 32-bit word: encode stage -> output FIFO, address-tagged.
// Optional macro INSTR_ENC_CHECK_EN adds immediate range checking; undefined means truncation only.
module instruction_encoder #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_imm,
    output logic [7:0]  err_count
);

    // The registered output word is one FIFO entry; the rest live in a small circular buffer.
    localparam int unsigned MEM_DEPTH = FIFO_DEPTH - 1;
    localparam int unsigned PTR_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(MEM_DEPTH + 1);

    typedef enum logic [6:0] {
        OP_R       = 7'h33,
        OP_I_LOGIC = 7'h13,
        OP_I_LOAD  = 7'h03,
        OP_I_JALR  = 7'h67,
        OP_S       = 7'h23,
        OP_B       = 7'h63,
        OP_J       = 7'h6F,
        OP_U_LUI   = 7'h37,
        OP_U_AUIPC = 7'h17
    } opcode_t;

`ifdef INSTR_ENC_CHECK_EN
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
        logic signed [31:0] s;
        s = $signed(v) >>> msb;
        return (s == '0) || (s == '1);
    endfunction
`else
    logic unused_imm_lsb;
    assign unused_imm_lsb = imm[0];
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [31:0] enc_instr;
    logic        enc_err;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        enc_instr = '0;
        enc_err   = 1'b0;
        case (opcode)
            OP_R: enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_I_LOGIC, OP_I_LOAD, OP_I_JALR: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef INSTR_ENC_CHECK_EN
                enc_err = !fits_signed(imm, 11);
`endif
            end
            OP_S: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef INSTR_ENC_CHECK_EN
                enc_err = !fits_signed(imm, 11);
`endif
            end
            OP_B: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef INSTR_ENC_CHECK_EN
                enc_err = !fits_signed(imm, 12) || imm[0];
`endif
            end
            OP_J: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef INSTR_ENC_CHECK_EN
                enc_err = !fits_signed(imm, 20) || imm[0];
`endif
            end
            OP_U_LUI, OP_U_AUIPC: begin
                enc_instr = {imm[31:12], rd, opcode};
`ifdef INSTR_ENC_CHECK_EN
                enc_err = (imm[11:0] != 12'h000);
`endif
            end
            default: enc_err = 1'b1;
        endcase
    end

    logic              stage_valid_q;
    logic              stage_err_q;
    logic [31:0]       stage_instr_q;
    logic [31:0]       mem_q [MEM_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  mem_cnt_q;
    logic [CNT_W-1:0]  mem_cnt_d;
    logic              out_valid_q;
    logic [31:0]       out_instr_q;
    logic [31:0]       out_addr_q;
    logic              err_imm_q;
    logic [7:0]        err_count_q;

    logic fifo_full;
    logic accept;
    logic drain;
    logic push;
    logic load_out;

    assign fifo_full = (mem_cnt_q == CNT_W'(MEM_DEPTH));
    assign in_ready  = !stage_valid_q || !fifo_full;
    assign accept    = in_valid && in_ready;
    assign drain     = stage_valid_q && !fifo_full;
    assign push      = drain && !stage_err_q;
    // Refill the output register whenever it is empty or being consumed this cycle.
    assign load_out  = (!out_valid_q || out_ready) && (mem_cnt_q != '0);

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        case ({push, load_out})
            2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
            2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
            default: mem_cnt_d = mem_cnt_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= stage_instr_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            stage_valid_q <= 1'b0;
            stage_err_q   <= 1'b0;
            stage_instr_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_addr_q    <= BASE_ADDR;
            err_imm_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            if (accept) begin
                stage_valid_q <= 1'b1;
                stage_err_q   <= enc_err;
                stage_instr_q <= enc_instr;
            end else if (drain) begin
                stage_valid_q <= 1'b0;
            end

            err_imm_q <= drain && stage_err_q;
            if (drain && stage_err_q && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end

            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (load_out) begin
                out_instr_q <= mem_q[rd_ptr_q];
                rd_ptr_q    <= ptr_inc(rd_ptr_q);
            end
            out_valid_q <= load_out || (out_valid_q && !out_ready);
            mem_cnt_q   <= mem_cnt_d;

            if (out_valid_q && out_ready) begin
                out_addr_q <= out_addr_q + ADDR_STEP;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign err_imm   = err_imm_q;
    assign err_count = err_count_q;

endmodule
